regfile_wb_ctrl: RTL and testbench

- Writeback controller; drives the register file write port (RegWrite/RD/WriteData) from two sources: single-cycle ALU results and in-order load responses from data memory.
- Holds an in-order load-tag queue of destination registers for outstanding loads.
- Provides scoreboard hazard flags for the decode-stage source registers.
- Arbitrates ALU and memory writes and guarantees write-after-write order per register.

---
 rtl/regfile_wb_ctrl_pkg.sv | 28 ++
 rtl/wb_load_tag_fifo.sv | 90 +++++++++
 rtl/regfile_wb_ctrl.sv | 163 ++++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_wb_pkg
// Purpose : Shared constants, write-source encoding and helpers for the
//           register-file writeback controller.
// Contents: XLEN, REG_AW constants; wb_src_t enum; reg_is_zero().
// Revision: 1.0 - initial release
// ============================================================================
package riscv_wb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    // Registered write-source select; NONE means no register-file write.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_MEM  = 2'd2
    } wb_src_t;

    // x0 is hardwired to zero: writes to it are suppressed and it never
    // has a hazard.
    function automatic logic reg_is_zero(input logic [REG_AW-1:0] idx);
        return (idx == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_load_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_load_tag_fifo
// Purpose : In-order queue of destination-register tags for outstanding
//           loads. Exposes every slot's valid bit and tag so the parent can
//           run scoreboard compares without walking the queue.
// Ports   : clk, reset (async, active-high)
//           push_valid/push_tag - enqueue, ignored when full
//           pop_valid           - dequeue head, ignored when empty
//           full, empty, head_tag
//           entry_valid/entry_tag - per-slot occupancy and tag
// Revision: 1.0 - initial release
// ============================================================================
module wb_load_tag_fifo #(
    parameter int LQ_DEPTH = 4,
    parameter int TAG_W    = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_valid,
    input  logic [TAG_W-1:0]                 push_tag,
    input  logic                             pop_valid,
    output logic                             full,
    output logic                             empty,
    output logic [TAG_W-1:0]                 head_tag,
    output logic [LQ_DEPTH-1:0]              entry_valid,
    output logic [LQ_DEPTH-1:0][TAG_W-1:0]   entry_tag
);

    localparam int IDX_W = $clog2(LQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [LQ_DEPTH-1:0][TAG_W-1:0]  tag_mem_q, tag_mem_d;
    logic [PTR_W-1:0]                w_count;
    logic                            w_push;
    logic                            w_pop;

    // Pointers carry one extra wrap bit: equal index with differing MSB
    // means every slot is occupied.
    assign full     = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    // Push acceptance looks only at registered fullness, so a same-cycle
    // pop never frees room for the push.
    assign w_push   = push_valid && !full;
    assign w_pop    = pop_valid && !empty;
    assign w_count  = wr_ptr_q - rd_ptr_q;
    assign head_tag = tag_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign entry_tag = tag_mem_q;

    // A slot is live when its distance from the head is below the count.
    always_comb begin : entry_valid_calc
        logic [IDX_W-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            offset         = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
            entry_valid[i] = ({1'b0, offset} < w_count);
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tag_mem_d = tag_mem_q;
        if (w_push) begin
            tag_mem_d[wr_ptr_q[IDX_W-1:0]] = push_tag;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_mem_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tag_mem_q <= tag_mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_ctrl
// Purpose : Writeback controller driving the register-file write port from
//           single-cycle ALU results and in-order load responses. Tracks
//           outstanding load destinations, raises decode hazard flags and
//           keeps write-after-write order per register.
// Ports   : clk, reset (async, active-high)
//           alu_valid/alu_ready/alu_rd/alu_data       - ALU result handshake
//           ld_issue_valid/ld_issue_ready/ld_issue_rd - load issue
//           mem_resp_valid/mem_resp_data             - in-order load data
//           RS1, RS2 -> rs1_pending, rs2_pending      - scoreboard
//           RegWrite, RD, WriteData                   - registered write port
//           resp_err                                  - sticky stray response
// Config  : WB_BYPASS_EN adds rs*_fwd_valid / rs*_fwd_data bypass outputs.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
    import riscv_wb_pkg::*;
#(
    parameter int XLEN     = riscv_wb_pkg::XLEN,
    parameter int REG_AW   = riscv_wb_pkg::REG_AW,
    parameter int LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_issue_valid,
    output logic              ld_issue_ready,
    input  logic [REG_AW-1:0] ld_issue_rd,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    input  logic [REG_AW-1:0] RS1,
    input  logic [REG_AW-1:0] RS2,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic              RegWrite,
    output logic [REG_AW-1:0] RD,
    output logic [XLEN-1:0]   WriteData,
    output logic              resp_err
`ifdef WB_BYPASS_EN
    ,
    output logic              rs1_fwd_valid,
    output logic              rs2_fwd_valid,
    output logic [XLEN-1:0]   rs1_fwd_data,
    output logic [XLEN-1:0]   rs2_fwd_data
`endif
);

    logic                             w_full;
    logic                             w_empty;
    logic [REG_AW-1:0]                w_head_rd;
    logic [LQ_DEPTH-1:0]              w_entry_valid;
    logic [LQ_DEPTH-1:0][REG_AW-1:0]  w_entry_rd;

    logic                             w_alu_blocked;
    logic                             w_rs1_hit;
    logic                             w_rs2_hit;
    logic                             w_alu_fire;
    logic                             w_mem_pop;
    logic                             w_stray_resp;

    wb_src_t                          src_q, src_d;
    logic [REG_AW-1:0]                rd_q, rd_d;
    logic [XLEN-1:0]                  wdata_q, wdata_d;
    logic                             resp_err_q, resp_err_d;

    wb_load_tag_fifo #(
        .LQ_DEPTH (LQ_DEPTH),
        .TAG_W    (REG_AW)
    ) u_load_tags (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (ld_issue_valid),
        .push_tag    (ld_issue_rd),
        .pop_valid   (mem_resp_valid),
        .full        (w_full),
        .empty       (w_empty),
        .head_tag    (w_head_rd),
        .entry_valid (w_entry_valid),
        .entry_tag   (w_entry_rd)
    );

    // Compare every live slot against the ALU destination and both decode
    // sources. The head slot being popped this cycle is still live here,
    // which is intended: its write only lands after the next edge.
    always_comb begin
        w_alu_blocked = 1'b0;
        w_rs1_hit     = 1'b0;
        w_rs2_hit     = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                if (w_entry_rd[i] == alu_rd) w_alu_blocked = 1'b1;
                if (w_entry_rd[i] == RS1)    w_rs1_hit     = 1'b1;
                if (w_entry_rd[i] == RS2)    w_rs2_hit     = 1'b1;
            end
        end
    end

    assign rs1_pending    = w_rs1_hit && !reg_is_zero(RS1);
    assign rs2_pending    = w_rs2_hit && !reg_is_zero(RS2);

    // Memory owns the port whenever it responds; an ALU result aimed at a
    // register with a load still in flight waits so the older load writes
    // first.
    assign alu_ready      = !mem_resp_valid && !w_alu_blocked;
    assign ld_issue_ready = !w_full;

    assign w_alu_fire     = alu_valid && alu_ready;
    assign w_mem_pop      = mem_resp_valid && !w_empty;
    assign w_stray_resp   = mem_resp_valid && w_empty;

    always_comb begin
        src_d      = WB_SRC_NONE;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        resp_err_d = resp_err_q | w_stray_resp;
        if (w_mem_pop) begin
            if (!reg_is_zero(w_head_rd)) begin
                src_d   = WB_SRC_MEM;
                rd_d    = w_head_rd;
                wdata_d = mem_resp_data;
            end
        end else if (w_alu_fire && !reg_is_zero(alu_rd)) begin
            src_d   = WB_SRC_ALU;
            rd_d    = alu_rd;
            wdata_d = alu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q      <= WB_SRC_NONE;
            rd_q       <= '0;
            wdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            src_q      <= src_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign RegWrite  = (src_q != WB_SRC_NONE);
    assign RD        = rd_q;
    assign WriteData = wdata_q;
    assign resp_err  = resp_err_q;

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle so decode does not read
    // the stale register-file copy.
    assign rs1_fwd_valid = RegWrite && (RD == RS1) && !reg_is_zero(RS1);
    assign rs2_fwd_valid = RegWrite && (RD == RS2) && !reg_is_zero(RS2);
    assign rs1_fwd_data  = WriteData;
    assign rs2_fwd_data  = WriteData;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_ctrl
// Purpose : Self-checking bench for regfile_wb_ctrl. A queue-based reference
//           model predicts the write port, handshakes, scoreboard flags and
//           error flag every cycle; directed sequences add literal checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    localparam int XW = 64;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_rd = '0;
    logic [XW-1:0] alu_data = '0;
    logic          ld_issue_valid = 1'b0;
    logic          ld_issue_ready;
    logic [AW-1:0] ld_issue_rd = '0;
    logic          mem_resp_valid = 1'b0;
    logic [XW-1:0] mem_resp_data = '0;
    logic [AW-1:0] RS1 = '0;
    logic [AW-1:0] RS2 = '0;
    logic          rs1_pending, rs2_pending;
    logic          RegWrite;
    logic [AW-1:0] RD;
    logic [XW-1:0] WriteData;
    logic          resp_err;
`ifdef WB_BYPASS_EN
    logic          rs1_fwd_valid, rs2_fwd_valid;
    logic [XW-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_ctrl #(.XLEN(XW), .REG_AW(AW), .LQ_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_ready (ld_issue_ready),
        .ld_issue_rd    (ld_issue_rd),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .RS1            (RS1),
        .RS2            (RS2),
        .rs1_pending    (rs1_pending),
        .rs2_pending    (rs2_pending),
        .RegWrite       (RegWrite),
        .RD             (RD),
        .WriteData      (WriteData),
        .resp_err       (resp_err)
`ifdef WB_BYPASS_EN
        ,
        .rs1_fwd_valid  (rs1_fwd_valid),
        .rs2_fwd_valid  (rs2_fwd_valid),
        .rs1_fwd_data   (rs1_fwd_data),
        .rs2_fwd_data   (rs2_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW-1:0] m_q[$];        // outstanding load destinations, oldest first
    bit            m_we = 0;
    logic [AW-1:0] m_rd = '0;
    logic [XW-1:0] m_wd = '0;
    bit            m_err = 0;
    bit            m_alu_hold = 0; // ALU offered but refused: stimulus must hold

    function automatic bit in_queue(input logic [AW-1:0] r);
        foreach (m_q[k]) if (m_q[k] == r) return 1;
        return 0;
    endfunction

    // Compare on the falling edge, then advance the model to what the next
    // rising edge must produce.
    always @(negedge clk) begin : compare
        bit exp_alu_rdy, exp_full;
        logic [AW-1:0] head;
        if (reset) begin
            m_q.delete();
            m_we = 0; m_rd = '0; m_wd = '0; m_err = 0; m_alu_hold = 0;
        end
        exp_full    = (m_q.size() >= DEPTH);
        exp_alu_rdy = !mem_resp_valid && !in_queue(alu_rd);
        check("m_regwrite", {63'd0, RegWrite}, {63'd0, m_we});
        check("m_rd", {59'd0, RD}, {59'd0, m_rd});
        check("m_wdata", WriteData, m_wd);
        check("m_resp_err", {63'd0, resp_err}, {63'd0, m_err});
        check("m_ld_ready", {63'd0, ld_issue_ready}, {63'd0, !exp_full});
        check("m_alu_ready", {63'd0, alu_ready}, {63'd0, exp_alu_rdy});
        check("m_rs1_pend", {63'd0, rs1_pending}, {63'd0, (RS1 != 0) && in_queue(RS1)});
        check("m_rs2_pend", {63'd0, rs2_pending}, {63'd0, (RS2 != 0) && in_queue(RS2)});
`ifdef WB_BYPASS_EN
        check("m_fwd1_v", {63'd0, rs1_fwd_valid}, {63'd0, m_we && m_rd == RS1 && RS1 != 0});
        check("m_fwd2_v", {63'd0, rs2_fwd_valid}, {63'd0, m_we && m_rd == RS2 && RS2 != 0});
        check("m_fwd1_d", rs1_fwd_data, m_wd);
        check("m_fwd2_d", rs2_fwd_data, m_wd);
`endif
        if (!reset) begin
            m_we = 0;
            m_alu_hold = alu_valid && !exp_alu_rdy;
            if (mem_resp_valid) begin
                if (m_q.size() == 0) m_err = 1;
                else begin
                    head = m_q.pop_front();
                    if (head != 0) begin m_we = 1; m_rd = head; m_wd = mem_resp_data; end
                end
            end else if (alu_valid && exp_alu_rdy && alu_rd != 0) begin
                m_we = 1; m_rd = alu_rd; m_wd = alu_data;
            end
            if (ld_issue_valid && !exp_full) m_q.push_back(ld_issue_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; ld_issue_valid = 0; mem_resp_valid = 0;
    endtask

    task automatic issue(input logic [AW-1:0] r);
        ld_issue_valid = 1; ld_issue_rd = r;
        tick();
        ld_issue_valid = 0;
    endtask

    task automatic wr_chk(input string name, input logic [AW-1:0] r, input logic [XW-1:0] d);
        check({name, "_we"}, {63'd0, RegWrite}, 64'd1);
        check({name, "_rd"}, {59'd0, RD}, {59'd0, r});
        check({name, "_wd"}, WriteData, d);
    endtask

    initial begin
        tick(); tick();
        // reset state
        check("rst_we", {63'd0, RegWrite}, 64'd0);
        check("rst_rd", {59'd0, RD}, 64'd0);
        check("rst_wd", WriteData, 64'd0);
        check("rst_err", {63'd0, resp_err}, 64'd0);
        reset = 0;
        tick();

        // single ALU write, one cycle only, then x0 write suppressed
        alu_valid = 1; alu_rd = 8; alu_data = 22;
        tick();
        alu_valid = 0;
        wr_chk("alu8", 8, 22);
        tick();
        check("alu8_once", {63'd0, RegWrite}, 64'd0);
        check("alu8_hold", {59'd0, RD}, 64'd8);
        alu_valid = 1; alu_rd = 0; alu_data = 64'h33;
        tick();
        alu_valid = 0;
        check("alu_x0", {63'd0, RegWrite}, 64'd0);

        // four loads, queue fills, in-order retire
        issue(9); issue(10); issue(9); issue(3);
        RS1 = 9; #1;
        check("lq_full_rdy", {63'd0, ld_issue_ready}, 64'd0);
        check("lq_rs1_pend", {63'd0, rs1_pending}, 64'd1);
        mem_resp_valid = 1; mem_resp_data = 64'h15; tick();
        wr_chk("ld1", 9, 64'h15);
        mem_resp_data = 64'h16; tick();
        wr_chk("ld2", 10, 64'h16);
        mem_resp_data = 64'h17; #1;
        check("ld3_popping_pend", {63'd0, rs1_pending}, 64'd1);
        tick();
        wr_chk("ld3", 9, 64'h17);
        mem_resp_data = 64'h18; #1;
        check("ld3_cleared", {63'd0, rs1_pending}, 64'd0);
        tick();
        wr_chk("ld4", 3, 64'h18);
        mem_resp_valid = 0; RS1 = 0;

        // WAW: ALU to rd 10 waits behind a pending load to rd 10
        issue(10);
        alu_valid = 1; alu_rd = 10; alu_data = 64'h99; #1;
        check("waw_block", {63'd0, alu_ready}, 64'd0);
        tick();
        mem_resp_valid = 1; mem_resp_data = 64'h42;
        tick();
        mem_resp_valid = 0;
        wr_chk("waw_ld", 10, 64'h42);
        tick();
        alu_valid = 0;
        wr_chk("waw_alu", 10, 64'h99);

        // same-cycle memory and ALU: memory first
        issue(7);
        mem_resp_valid = 1; mem_resp_data = 64'h77;
        alu_valid = 1; alu_rd = 5; alu_data = 64'h55; #1;
        check("arb_alu_rdy", {63'd0, alu_ready}, 64'd0);
        tick();
        mem_resp_valid = 0;
        wr_chk("arb_mem", 7, 64'h77);
        tick();
        alu_valid = 0;
        wr_chk("arb_alu", 5, 64'h55);

        // full queue with simultaneous push and pop: push refused
        issue(1); issue(2); issue(3); issue(4);
        ld_issue_valid = 1; ld_issue_rd = 6;
        mem_resp_valid = 1; mem_resp_data = 64'hA1;
        tick();
        ld_issue_valid = 0; mem_resp_valid = 0;
        RS1 = 6; RS2 = 4; #1;
        wr_chk("full_pop", 1, 64'hA1);
        check("full_rdy_after", {63'd0, ld_issue_ready}, 64'd1);
        check("full_no_push", {63'd0, rs1_pending}, 64'd0);
        check("full_keep4", {63'd0, rs2_pending}, 64'd1);
        mem_resp_valid = 1; tick(); tick(); tick();
        // stray response on empty queue
        tick();
        mem_resp_valid = 0;
        check("stray_we", {63'd0, RegWrite}, 64'd0);
        check("stray_err", {63'd0, resp_err}, 64'd1);
        tick();
        check("stray_sticky", {63'd0, resp_err}, 64'd1);

        // asynchronous reset with two loads outstanding
        issue(11); issue(12);
        RS1 = 11; RS2 = 12;
        alu_valid = 1; alu_rd = 13; alu_data = 7;
        tick();
        alu_valid = 0;
        check("pre_rst_we", {63'd0, RegWrite}, 64'd1);
        reset = 1; #1;
        check("arst_we", {63'd0, RegWrite}, 64'd0);
        check("arst_pend1", {63'd0, rs1_pending}, 64'd0);
        check("arst_pend2", {63'd0, rs2_pending}, 64'd0);
        check("arst_err", {63'd0, resp_err}, 64'd0);
        tick();
        reset = 0;
        tick();
        mem_resp_valid = 1; tick();
        mem_resp_valid = 0;
        check("post_rst_stray", {63'd0, resp_err}, 64'd1);
        check("post_rst_we", {63'd0, RegWrite}, 64'd0);

`ifdef WB_BYPASS_EN
        alu_valid = 1; alu_rd = 8; alu_data = 64'h88;
        tick();
        alu_valid = 0; RS2 = 8; #1;
        check("fwd_v", {63'd0, rs2_fwd_valid}, 64'd1);
        check("fwd_d", rs2_fwd_data, 64'h88);
        RS2 = 0; #1;
        check("fwd_x0", {63'd0, rs2_fwd_valid}, 64'd0);
        tick();
`endif

        // randomized traffic against the model
        reset = 1; idle(); tick(); reset = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin reset = 1; idle(); tick(); reset = 0; end
            ld_issue_valid = ($urandom_range(0, 9) < 4);
            ld_issue_rd    = AW'($urandom_range(0, 7));
            if (m_q.size() != 0) mem_resp_valid = ($urandom_range(0, 9) < 4);
            else                 mem_resp_valid = ($urandom_range(0, 99) < 2);
            mem_resp_data  = {$urandom, $urandom};
            if (!m_alu_hold) begin
                alu_valid = ($urandom_range(0, 1) == 1);
                alu_rd    = AW'($urandom_range(0, 7));
                alu_data  = {$urandom, $urandom};
            end
            RS1 = AW'($urandom_range(0, 7));
            RS2 = AW'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
